// File: rtl/pipe_seq_pkg.sv
// Shared constants, state encodings and forwarding helper for the pipeline phase sequencer.
package pipe_seq_pkg;

    localparam int unsigned NUM_PHASES  = 5;
    localparam int unsigned FLUSH_SLOTS = 2;
    localparam int unsigned STALL_MAX   = 15;
    localparam int unsigned MEM_PHASE   = 2;
    localparam int unsigned STALL_W     = 4;
    localparam int unsigned FLUSH_W     = $clog2(FLUSH_SLOTS + 1);

    typedef enum logic [2:0] {
        PH_LATCH = 3'd0,
        PH_FETCH = 3'd1,
        PH_MEM   = 3'd2,
        PH_REG   = 3'd3,
        PH_ALU   = 3'd4
    } phase_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [4:0] XZR = 5'd31;

    // The zero register never carries a live result, so it is never forwarded.
    function automatic logic fwd_match(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
        return wr && (rd == rs) && (rd != XZR);
    endfunction

endpackage

// File: rtl/phase_ring.sv
// One-hot phase ring: clear empties it, hold freezes it, otherwise it rotates.
// Advancing from the empty ring loads the first phase, which is how a slot starts.
module phase_ring
    import pipe_seq_pkg::*;
#(
    parameter int unsigned NUM = NUM_PHASES
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_hold,
    input  logic           i_clear,
    output logic [NUM-1:0] o_ring
);

    logic [NUM-1:0] r_ring;
    logic [NUM-1:0] w_next;

    always_comb begin
        w_next = r_ring << 1;
        if (r_ring == '0 || r_ring[NUM-1]) begin
            w_next = {{(NUM-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ring <= '0;
        end else if (i_clear) begin
            r_ring <= '0;
        end else if (!i_hold) begin
            r_ring <= w_next;
        end
    end

    assign o_ring = r_ring;

endmodule

// File: rtl/pipe_phase_sequencer.sv
// Five-phase strobe sequencer: run/stall/halt control, branch flush bubbles,
// registered Writeback->Execute forward selects and retired-slot counting.
module pipe_phase_sequencer
    import pipe_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_run,
    input  logic        i_mem_busy,
    input  logic        i_wb_branch,
    input  logic        i_wb_reg_write,
    input  logic [4:0]  i_wb_rd,
    input  logic [4:0]  i_ex_rs1,
    input  logic [4:0]  i_ex_rs2,
    output logic [4:0]  o_phases,
    output logic        o_flush,
    output logic        o_fwd1,
    output logic        o_fwd2,
    output logic [15:0] o_slot_count,
    output logic        o_fault
);

    logic [1:0]         r_state;
    logic [STALL_W-1:0] r_stall_cnt;
    logic [FLUSH_W-1:0] r_flush_cnt;
    logic               r_flush;
    logic               r_fwd1;
    logic               r_fwd2;
    logic [15:0]        r_slot_count;
    logic               r_fault;

    logic [1:0]         w_state_d;
    logic [STALL_W-1:0] w_stall_cnt_d;
    logic [FLUSH_W-1:0] w_flush_cnt_d;
    logic               w_fault_d;
    logic               w_hold;
    logic               w_clear;
    logic               w_enter_slot;
    logic               w_slot_end;
    logic               w_flush_next;
    logic [4:0]         w_ring;

    phase_ring #(
        .NUM (NUM_PHASES)
    ) u_ring (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_hold  (w_hold),
        .i_clear (w_clear),
        .o_ring  (w_ring)
    );

    always_comb begin
        w_state_d     = r_state;
        w_stall_cnt_d = r_stall_cnt;
        w_fault_d     = r_fault;
        w_hold        = 1'b1;
        w_clear       = 1'b0;
        w_enter_slot  = 1'b0;
        w_slot_end    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_run && !r_fault) begin
                    w_state_d    = ST_RUN;
                    w_hold       = 1'b0;
                    w_enter_slot = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_ring[MEM_PHASE] && i_mem_busy) begin
                    w_state_d     = ST_STALL;
                    w_stall_cnt_d = STALL_W'(1);
                end else begin
                    w_hold = 1'b0;
                    // Run is only honoured at the slot boundary so a slot is never cut short.
                    if (w_ring[PH_ALU]) begin
                        w_slot_end = 1'b1;
                        if (i_run) begin
                            w_enter_slot = 1'b1;
                        end else begin
                            w_state_d = ST_IDLE;
                            w_clear   = 1'b1;
                        end
                    end
                end
            end
            ST_STALL: begin
                if (!i_mem_busy) begin
                    w_state_d     = ST_RUN;
                    w_hold        = 1'b0;
                    w_stall_cnt_d = '0;
                end else if (r_stall_cnt == STALL_W'(STALL_MAX)) begin
                    w_state_d     = ST_HALT;
                    w_clear       = 1'b1;
                    w_fault_d     = 1'b1;
                    w_stall_cnt_d = '0;
                end else begin
                    w_stall_cnt_d = r_stall_cnt + STALL_W'(1);
                end
            end
            default: begin
                w_clear = 1'b1;
            end
        endcase
    end

    // Bubbles cannot branch, so a bubble slot only counts the flush down.
    always_comb begin
        w_flush_cnt_d = r_flush_cnt;
        if (w_slot_end) begin
            if (r_flush) begin
                w_flush_cnt_d = r_flush_cnt - FLUSH_W'(1);
            end else if (i_wb_branch) begin
                w_flush_cnt_d = FLUSH_W'(FLUSH_SLOTS);
            end
        end
    end

    assign w_flush_next = (w_flush_cnt_d != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_flush      <= 1'b0;
            r_fwd1       <= 1'b0;
            r_fwd2       <= 1'b0;
            r_slot_count <= 16'd0;
            r_fault      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_stall_cnt <= w_stall_cnt_d;
            r_fault     <= w_fault_d;
            r_flush_cnt <= w_flush_cnt_d;
            if (w_enter_slot) begin
                r_flush <= w_flush_next;
                r_fwd1  <= fwd_match(i_wb_reg_write, i_wb_rd, i_ex_rs1) && !w_flush_next;
                r_fwd2  <= fwd_match(i_wb_reg_write, i_wb_rd, i_ex_rs2) && !w_flush_next;
            end else if (w_clear) begin
                r_flush <= 1'b0;
                r_fwd1  <= 1'b0;
                r_fwd2  <= 1'b0;
            end
            if (w_slot_end && !r_flush) begin
                r_slot_count <= r_slot_count + 16'd1;
            end
        end
    end

    assign o_phases     = w_ring;
    assign o_flush      = r_flush;
    assign o_fwd1       = r_fwd1;
    assign o_fwd2       = r_fwd2;
    assign o_slot_count = r_slot_count;
    assign o_fault      = r_fault;

endmodule

// File: tb/tb_pipe_phase_sequencer.sv
// Scoreboard bench for pipe_phase_sequencer: per-cycle expectations are queued as stimulus is
// driven and compared against the outputs on the following falling edge.
module tb_pipe_phase_sequencer;

    typedef struct packed {
        logic [4:0]  ph;
        logic        fl;
        logic        f1;
        logic        f2;
        logic [15:0] sc;
        logic        ft;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_run;
    logic        i_mem_busy;
    logic        i_wb_branch;
    logic        i_wb_reg_write;
    logic [4:0]  i_wb_rd;
    logic [4:0]  i_ex_rs1;
    logic [4:0]  i_ex_rs2;
    logic [4:0]  o_phases;
    logic        o_flush;
    logic        o_fwd1;
    logic        o_fwd2;
    logic [15:0] o_slot_count;
    logic        o_fault;

    exp_t obs;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    assign obs = {o_phases, o_flush, o_fwd1, o_fwd2, o_slot_count, o_fault};

    always #5 clk = ~clk;

    pipe_phase_sequencer dut (
        .i_clk          (clk),
        .i_rst_n        (i_rst_n),
        .i_run          (i_run),
        .i_mem_busy     (i_mem_busy),
        .i_wb_branch    (i_wb_branch),
        .i_wb_reg_write (i_wb_reg_write),
        .i_wb_rd        (i_wb_rd),
        .i_ex_rs1       (i_ex_rs1),
        .i_ex_rs2       (i_ex_rs2),
        .o_phases       (o_phases),
        .o_flush        (o_flush),
        .o_fwd1         (o_fwd1),
        .o_fwd2         (o_fwd2),
        .o_slot_count   (o_slot_count),
        .o_fault        (o_fault)
    );

    task automatic clear_inputs();
        i_run          = 1'b0;
        i_mem_busy     = 1'b0;
        i_wb_branch    = 1'b0;
        i_wb_reg_write = 1'b0;
        i_wb_rd        = 5'd0;
        i_ex_rs1       = 5'd0;
        i_ex_rs2       = 5'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        i_rst_n = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_initial got %h want 0", obs);
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        for (int c = 0; c < 13; c++) begin
            i_run = 1'b1;
            e = '{ph: 5'(1 << (c % 5)), fl: 1'b0, f1: 1'b0, f2: 1'b0, sc: 16'(c / 5), ft: 1'b0};
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_seq c=%0d got ph=%b fl=%b fw=%b%b sc=%h ft=%b want ph=%b fl=%b fw=%b%b sc=%h ft=%b",
                         c, obs.ph, obs.fl, obs.f1, obs.f2, obs.sc, obs.ft,
                         e.ph, e.fl, e.f1, e.f2, e.sc, e.ft);
            end
        end
        // Ring now sits at 00100; pull reset between edges.
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_async got %h want 0", obs);
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            e = '{ph: 5'(1 << (c % 5)), fl: 1'b0, f1: 1'b0, f2: 1'b0, sc: 16'(c / 5), ft: 1'b0};
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_restart c=%0d got ph=%b fl=%b fw=%b%b sc=%h ft=%b want ph=%b fl=%b fw=%b%b sc=%h ft=%b",
                         c, obs.ph, obs.fl, obs.f1, obs.f2, obs.sc, obs.ft,
                         e.ph, e.fl, e.f1, e.f2, e.sc, e.ft);
            end
        end
    endtask

    task automatic test_stall();
        exp_t       e;
        logic [4:0] ph_tab [14];
        ph_tab = '{5'b00001, 5'b00010, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01000,
                   5'b10000, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        do_reset();
        for (int c = 0; c < 14; c++) begin
            i_run      = 1'b1;
            i_mem_busy = (c >= 3 && c <= 5) || (c == 9);
            e = '{ph: ph_tab[c], fl: 1'b0, f1: 1'b0, f2: 1'b0,
                  sc: (c < 8) ? 16'd0 : (c < 13) ? 16'd1 : 16'd2, ft: 1'b0};
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL stall c=%0d got ph=%b fl=%b fw=%b%b sc=%h ft=%b want ph=%b fl=%b fw=%b%b sc=%h ft=%b",
                         c, obs.ph, obs.fl, obs.f1, obs.f2, obs.sc, obs.ft,
                         e.ph, e.fl, e.f1, e.f2, e.sc, e.ft);
            end
        end
    endtask

    task automatic test_fault();
        exp_t e;
        do_reset();
        for (int c = 0; c < 25; c++) begin
            i_run      = !(c >= 19 && c < 21);
            i_mem_busy = (c >= 3);
            e = '{ph: (c < 2) ? 5'(1 << c) : (c <= 17) ? 5'b00100 : 5'b00000,
                  fl: 1'b0, f1: 1'b0, f2: 1'b0, sc: 16'd0, ft: (c >= 18)};
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL fault c=%0d got ph=%b fl=%b fw=%b%b sc=%h ft=%b want ph=%b fl=%b fw=%b%b sc=%h ft=%b",
                         c, obs.ph, obs.fl, obs.f1, obs.f2, obs.sc, obs.ft,
                         e.ph, e.fl, e.f1, e.f2, e.sc, e.ft);
            end
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_fault !== 1'b0 || o_phases !== 5'b0) begin
            errors++;
            $display("FAIL fault_reset got fault=%b ph=%b want fault=0 ph=00000", o_fault, o_phases);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        logic fl;
        do_reset();
        for (int c = 0; c < 21; c++) begin
            i_run          = 1'b1;
            i_wb_reg_write = 1'b1;
            i_wb_rd        = 5'd7;
            i_ex_rs1       = 5'd7;
            i_ex_rs2       = 5'd7;
            i_wb_branch    = (c == 5) || (c == 10);
            fl = (c >= 5 && c <= 14);
            e = '{ph: 5'(1 << (c % 5)), fl: fl, f1: !fl, f2: !fl,
                  sc: (c < 5) ? 16'd0 : (c < 20) ? 16'd1 : 16'd2, ft: 1'b0};
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL flush c=%0d got ph=%b fl=%b fw=%b%b sc=%h ft=%b want ph=%b fl=%b fw=%b%b sc=%h ft=%b",
                         c, obs.ph, obs.fl, obs.f1, obs.f2, obs.sc, obs.ft,
                         e.ph, e.fl, e.f1, e.f2, e.sc, e.ft);
            end
        end
    endtask

    task automatic test_forward();
        exp_t e;
        logic f1_tab [5];
        logic f2_tab [5];
        f1_tab = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        f2_tab = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int c = 0; c < 25; c++) begin
            i_run = 1'b1;
            // Operands change mid-slot; the selects must only follow them at slot start.
            if (c < 2) begin
                i_wb_reg_write = 1'b1; i_wb_rd = 5'd7;  i_ex_rs1 = 5'd7;  i_ex_rs2 = 5'd3;
            end else if (c < 7) begin
                i_wb_reg_write = 1'b1; i_wb_rd = 5'd3;  i_ex_rs1 = 5'd7;  i_ex_rs2 = 5'd3;
            end else if (c < 12) begin
                i_wb_reg_write = 1'b1; i_wb_rd = 5'd31; i_ex_rs1 = 5'd31; i_ex_rs2 = 5'd31;
            end else if (c < 17) begin
                i_wb_reg_write = 1'b0; i_wb_rd = 5'd7;  i_ex_rs1 = 5'd7;  i_ex_rs2 = 5'd7;
            end else begin
                i_wb_reg_write = 1'b1; i_wb_rd = 5'd7;  i_ex_rs1 = 5'd7;  i_ex_rs2 = 5'd7;
            end
            e = '{ph: 5'(1 << (c % 5)), fl: 1'b0, f1: f1_tab[c / 5], f2: f2_tab[c / 5],
                  sc: 16'(c / 5), ft: 1'b0};
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL forward c=%0d got ph=%b fl=%b fw=%b%b sc=%h ft=%b want ph=%b fl=%b fw=%b%b sc=%h ft=%b",
                         c, obs.ph, obs.fl, obs.f1, obs.f2, obs.sc, obs.ft,
                         e.ph, e.fl, e.f1, e.f2, e.sc, e.ft);
            end
        end
    endtask

    task automatic test_stop_wrap();
        exp_t e;
        do_reset();
        // Run drops at phase 1; branch and stop coincide at the slot's last phase.
        for (int c = 0; c < 8; c++) begin
            i_run       = (c < 2);
            i_wb_branch = (c == 5);
            e = '{ph: (c < 5) ? 5'(1 << c) : 5'b00000, fl: 1'b0, f1: 1'b0, f2: 1'b0,
                  sc: (c < 5) ? 16'd0 : 16'd1, ft: 1'b0};
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL stop c=%0d got ph=%b fl=%b fw=%b%b sc=%h ft=%b want ph=%b fl=%b fw=%b%b sc=%h ft=%b",
                         c, obs.ph, obs.fl, obs.f1, obs.f2, obs.sc, obs.ft,
                         e.ph, e.fl, e.f1, e.f2, e.sc, e.ft);
            end
        end
        i_wb_branch = 1'b0;
        force dut.r_slot_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_slot_count;
        // Retained flush count is applied on restart, then the counter wraps.
        for (int c = 0; c < 21; c++) begin
            i_run = 1'b1;
            e = '{ph: 5'(1 << (c % 5)), fl: (c < 10), f1: 1'b0, f2: 1'b0,
                  sc: (c < 15) ? 16'hFFFE : (c < 20) ? 16'hFFFF : 16'h0000, ft: 1'b0};
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL wrap c=%0d got ph=%b fl=%b fw=%b%b sc=%h ft=%b want ph=%b fl=%b fw=%b%b sc=%h ft=%b",
                         c, obs.ph, obs.fl, obs.f1, obs.f2, obs.sc, obs.ft,
                         e.ph, e.fl, e.f1, e.f2, e.sc, e.ft);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stall();
        test_fault();
        test_flush();
        test_forward();
        test_stop_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
